mem_arb: RTL and testbench
==========================

Name: mem_arb

Overview:
- Two-port arbiter/sequencer that shares one single-port unified memory between the instruction-fetch path (IF) and the load/store data path (DM) of the multicycle core.
- Sits between the core's fetch/memory stages and the memory array.
- Accepts single-cycle request pulses, holds them pending, grants one port at a time and drives the memory for a fixed latency.
- Returns read data with a one-cycle ready pulse.

Parameters:
AW, 32, address width
DW, 32, data width
MEM_LAT, 2, cycles from mem_en issue to valid mem_rdata; legal range >= 1
ST_MAX, 4, consecutive DM grants allowed while IF is pending before IF is forced

Ports:
clk  in  1  clock, rising edge
clr  in  1  synchronous active-low reset; clr=0 sampled at a rising edge resets the block
if_req  in  1  IF request pulse, one cycle
if_addr  in  AW  IF address, sampled with if_req
if_gnt  out  1  IF granted; one-cycle pulse
if_rdy  out  1  IF read data valid; one-cycle pulse
if_rdata  out  DW  IF read data
dm_req  in  1  DM request pulse, one cycle
dm_we  in  1  DM write when 1, read when 0; sampled with dm_req
dm_addr  in  AW  DM address, sampled with dm_req
dm_wdata  in  DW  DM write data, sampled with dm_req
dm_gnt  out  1  DM granted; one-cycle pulse
dm_rdy  out  1  DM access complete; one-cycle pulse
dm_rdata  out  DW  DM read data
mem_en  out  1  memory access strobe
mem_we  out  1  memory write enable, qualified by mem_en
mem_addr  out  AW  memory address
mem_wdata  out  DW  memory write data
mem_rdata  in  DW  memory read data
busy  out  1  1 when state != IDLE or any request is pending

Behaviour:
- Reset: state=IDLE; pending bits, latched requests, cnt and st_cnt cleared. Every output and rdata register = 0.
- Reset mid-access aborts the access: no rdy is issued and pending requests are lost.
- Request capture: a req pulse sets the port's pending bit and latches addr/we/wdata.
- A req on a port that is already pending or in service is ignored.
- FSM states: IDLE, ACC_IF, ACC_DM, RESP.
- IDLE: if any port is pending, select a winner and go to ACC_x; otherwise stay in IDLE. The winner's pending bit clears on the transition.
- ACC_x, first cycle (cnt=0): gnt_x=1, mem_en=1; mem_we = latched we (IF always 0).
- ACC_x, all cycles: mem_addr and mem_wdata hold the latched values.
- ACC_x: cnt increments each cycle. At cnt=MEM_LAT-1, mem_rdata is captured into rdata_x (reads only) and the FSM moves to RESP.
- RESP: rdy_x=1 for one cycle; next state is IDLE.
- Writes: rdy is still issued; dm_rdata keeps its previous value.
- Latency: req at cycle 0 → pending at cycle 1 (IDLE) → gnt/mem_en at cycle 2 → rdy at cycle 2+MEM_LAT.
- mem_en, mem_we and mem_wdata are 0 outside ACC. mem_addr is don't-care outside ACC; drive it 0.
- Rdata outputs hold their value until the next read completes on the same port.
- Arbitration, default: DM has priority over IF.
- st_cnt increments on each DM grant made while IF is pending, and clears on any IF grant.
- When st_cnt==ST_MAX and IF is pending, IF wins.
- A req arriving in the same cycle the FSM is in IDLE is not seen until the next cycle, because selection uses pending bits only.
- cnt width = $clog2(MEM_LAT+1); st_cnt width = $clog2(ST_MAX+1).

Optional Feature:
- Macro: MEM_ARB_RR_EN.
- Defined: when both ports are pending, the port not granted last wins (strict alternation); last-grant flag resets to DM, so IF wins the first tie. st_cnt is removed.
- Not defined: fixed DM priority with the ST_MAX starvation guard as above.

Decomposition:
- Package mem_arb_pkg: FSM state encodings (IDLE=2'd0, ACC_IF=2'd1, ACC_DM=2'd2, RESP=2'd3) and port IDs (PORT_IF=1'b0, PORT_DM=1'b1).
- Sub-module mem_arb_port: per-port pending bit plus addr/we/wdata holding register with ignore-while-busy logic. Instantiated twice.

Test Plan:
- Reset: clr=0 for 2 cycles with if_req=dm_req=1 → all outputs 0; no mem_en after clr=1 until a new req.
- IF read at 0x00003000, MEM_LAT=2, memory model returns 0x3c010001 → cycle 2: if_gnt=1, mem_en=1, mem_addr=0x00003000, mem_we=0. Cycle 4: if_rdy=1, if_rdata=0x3c010001.
- DM write to 0x00000010 with data 0xDEADBEEF → cycle 2: mem_en=1, mem_we=1, mem_wdata=0xDEADBEEF. Cycle 4: dm_rdy=1; dm_rdata unchanged.
- Simultaneous if_req and dm_req at cycle 0 → dm_gnt at 2, dm_rdy at 4, if_gnt at 6, if_rdy at 8. With MEM_ARB_RR_EN: IF is served first instead.
- Starvation, ST_MAX=4: IF pending while DM re-requests on every rdy → 4 DM grants, then the 5th grant goes to IF and st_cnt clears.
- Reset at the cycle after dm_gnt (ACC_DM) → no dm_rdy, busy=0 next cycle, memory untouched afterward.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: FSM state and port-id encodings shared by the memory arbiter
package mem_arb_pkg;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACC_IF = 2'd1,
    ACC_DM = 2'd2,
    RESP   = 2'd3
  } state_t;
  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_DM = 1'b1;
endpackage

// File: rtl/mem_arb_port.sv
// mem_arb_port: per-port pending bit and request holding register; requests ignored while pending or in service
module mem_arb_port #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          req,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  input  logic          svc,
  input  logic          take,
  output logic          pend,
  output logic          lat_we,
  output logic [AW-1:0] lat_addr,
  output logic [DW-1:0] lat_wdata
);
  always_ff @(posedge clk) begin
    if (!clr) begin
      pend      <= 1'b0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else if (req && !pend && !svc) begin
      pend      <= 1'b1;
      lat_we    <= we;
      lat_addr  <= addr;
      lat_wdata <= wdata;
    end else if (take) begin
      pend      <= 1'b0;
    end
  end
endmodule

// File: rtl/mem_arb.sv
// mem_arb: IF/DM arbiter for a shared single-port memory; define MEM_ARB_RR_EN for round-robin ties instead of DM priority with starvation guard
module mem_arb
  import mem_arb_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MEM_LAT = 2,
  parameter int ST_MAX  = 4
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rdy,
  output logic [DW-1:0] if_rdata,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic          dm_gnt,
  output logic          dm_rdy,
  output logic [DW-1:0] dm_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);
  localparam int CW = $clog2(MEM_LAT + 1);
  state_t state, nxt;
  logic [CW-1:0] cnt;
  logic cur, sel, go, if_take, dm_take, acc, last_acc;
  logic if_pend, if_lat_we, dm_pend, dm_lat_we;
  logic [AW-1:0] if_lat_addr, dm_lat_addr;
  logic [DW-1:0] if_lat_wdata, dm_lat_wdata;
  mem_arb_port #(.AW(AW), .DW(DW)) u_if (
    .clk(clk), .clr(clr), .req(if_req), .we(1'b0), .addr(if_addr), .wdata('0),
    .svc(state == ACC_IF), .take(if_take),
    .pend(if_pend), .lat_we(if_lat_we), .lat_addr(if_lat_addr), .lat_wdata(if_lat_wdata)
  );
  mem_arb_port #(.AW(AW), .DW(DW)) u_dm (
    .clk(clk), .clr(clr), .req(dm_req), .we(dm_we), .addr(dm_addr), .wdata(dm_wdata),
    .svc(state == ACC_DM), .take(dm_take),
    .pend(dm_pend), .lat_we(dm_lat_we), .lat_addr(dm_lat_addr), .lat_wdata(dm_lat_wdata)
  );
`ifdef MEM_ARB_RR_EN
  // cur doubles as the last-grant flag; it resets to DM so IF wins the first tie
  assign sel = (if_pend && dm_pend) ? ~cur : dm_pend;
`else
  localparam int SW = $clog2(ST_MAX + 1);
  logic [SW-1:0] st_cnt;
  assign sel = dm_pend && !(if_pend && st_cnt == SW'(ST_MAX));
  always_ff @(posedge clk) begin
    if (!clr) st_cnt <= '0;
    else if (if_take) st_cnt <= '0;
    else if (dm_take && if_pend) st_cnt <= st_cnt + 1'b1;
  end
`endif
  assign go       = state == IDLE && (if_pend || dm_pend);
  assign if_take  = go && sel == PORT_IF;
  assign dm_take  = go && sel == PORT_DM;
  assign acc      = state == ACC_IF || state == ACC_DM;
  assign last_acc = cnt == CW'(MEM_LAT - 1);
  always_comb begin
    nxt = state;
    if (state == IDLE) nxt = !go ? IDLE : sel == PORT_DM ? ACC_DM : ACC_IF;
    else if (state == RESP) nxt = IDLE;
    else if (last_acc) nxt = RESP;
  end
  always_ff @(posedge clk) begin
    if (!clr) begin
      state    <= IDLE;
      cnt      <= '0;
      cur      <= PORT_DM;
      if_rdata <= '0;
      dm_rdata <= '0;
    end else begin
      state <= nxt;
      cnt   <= (acc && !last_acc) ? cnt + 1'b1 : '0;
      if (go) cur <= sel;
      if (state == ACC_IF && last_acc) if_rdata <= mem_rdata;
      if (state == ACC_DM && last_acc && !dm_lat_we) dm_rdata <= mem_rdata;
    end
  end
  assign mem_en    = acc && cnt == '0;
  assign if_gnt    = mem_en && state == ACC_IF;
  assign dm_gnt    = mem_en && state == ACC_DM;
  assign if_rdy    = state == RESP && cur == PORT_IF;
  assign dm_rdy    = state == RESP && cur == PORT_DM;
  assign mem_we    = mem_en && (state == ACC_DM ? dm_lat_we : if_lat_we);
  assign mem_addr  = state == ACC_DM ? dm_lat_addr : state == ACC_IF ? if_lat_addr : '0;
  assign mem_wdata = state == ACC_DM ? dm_lat_wdata : state == ACC_IF ? if_lat_wdata : '0;
  assign busy      = state != IDLE || if_pend || dm_pend;
endmodule

// File: tb/tb_mem_arb.sv
// tb_mem_arb: directed self-checking bench for mem_arb with a small memory model
module tb_mem_arb;
  logic clk = 1'b0, clr = 1'b0;
  logic if_req = 1'b0, dm_req = 1'b0, dm_we = 1'b0;
  logic [31:0] if_addr = '0, dm_addr = '0, dm_wdata = '0;
  logic if_gnt, if_rdy, dm_gnt, dm_rdy, mem_en, mem_we, busy;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [31:0] wr_addr = 32'hffff_fff0, wr_data = '0;
  int en_cnt = 0;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  assign mem_rdata = mem_addr == 32'h0000_3000 ? 32'h3c01_0001 : mem_addr == wr_addr ? wr_data : 32'h0;
  always @(posedge clk) begin
    if (mem_en) en_cnt <= en_cnt + 1;
    if (mem_en && mem_we) begin
      wr_addr <= mem_addr;
      wr_data <= mem_wdata;
    end
  end
  mem_arb #(.AW(32), .DW(32), .MEM_LAT(2), .ST_MAX(4)) dut (
    .clk(clk), .clr(clr),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rdy(if_rdy), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_rdy(dm_rdy), .dm_rdata(dm_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    int e;
    clr = 1'b0; if_req = 1'b1; dm_req = 1'b1;
    tick; tick;
    checks++;
    if ({if_gnt, if_rdy, dm_gnt, dm_rdy, mem_en, mem_we, busy} !== 7'b0) begin
      errors++; $display("FAIL reset_ctl got %b exp 0000000", {if_gnt, if_rdy, dm_gnt, dm_rdy, mem_en, mem_we, busy});
    end
    checks++;
    if ({if_rdata, dm_rdata} !== 64'h0) begin
      errors++; $display("FAIL reset_rdata got %h exp 0", {if_rdata, dm_rdata});
    end
    checks++;
    if ({mem_addr, mem_wdata} !== 64'h0) begin
      errors++; $display("FAIL reset_mem got %h exp 0", {mem_addr, mem_wdata});
    end
    clr = 1'b1; if_req = 1'b0; dm_req = 1'b0;
    e = en_cnt;
    repeat (4) tick;
    checks++;
    if (en_cnt !== e || busy !== 1'b0) begin
      errors++; $display("FAIL reset_quiet got en %0d busy %b exp en %0d busy 0", en_cnt, busy, e);
    end
  endtask
  task automatic test_if_read;
    if_req = 1'b1; if_addr = 32'h0000_3000;
    tick; if_req = 1'b0;
    checks++;
    if ({busy, if_gnt, mem_en} !== 3'b100) begin
      errors++; $display("FAIL ifr_c1 got %b exp 100", {busy, if_gnt, mem_en});
    end
    tick;
    checks++;
    if ({if_gnt, mem_en, mem_we, dm_gnt} !== 4'b1100 || mem_addr !== 32'h0000_3000) begin
      errors++; $display("FAIL ifr_c2 got %b addr %h exp 1100 addr 00003000", {if_gnt, mem_en, mem_we, dm_gnt}, mem_addr);
    end
    tick;
    checks++;
    if ({if_gnt, mem_en, if_rdy} !== 3'b000 || mem_addr !== 32'h0000_3000) begin
      errors++; $display("FAIL ifr_c3 got %b addr %h exp 000 addr 00003000", {if_gnt, mem_en, if_rdy}, mem_addr);
    end
    tick;
    checks++;
    if (if_rdy !== 1'b1 || if_rdata !== 32'h3c01_0001) begin
      errors++; $display("FAIL ifr_c4 got rdy %b data %h exp rdy 1 data 3c010001", if_rdy, if_rdata);
    end
    tick;
    checks++;
    if ({if_rdy, busy, mem_addr} !== 34'h0) begin
      errors++; $display("FAIL ifr_c5 got %h exp 0", {if_rdy, busy, mem_addr});
    end
  endtask
  task automatic test_dm_read;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h0000_3000;
    tick; dm_req = 1'b0;
    tick;
    checks++;
    if ({dm_gnt, mem_en, mem_we, if_gnt} !== 4'b1100) begin
      errors++; $display("FAIL dmr_c2 got %b exp 1100", {dm_gnt, mem_en, mem_we, if_gnt});
    end
    tick; tick;
    checks++;
    if (dm_rdy !== 1'b1 || if_rdy !== 1'b0 || dm_rdata !== 32'h3c01_0001) begin
      errors++; $display("FAIL dmr_c4 got rdy %b/%b data %h exp rdy 1/0 data 3c010001", dm_rdy, if_rdy, dm_rdata);
    end
    tick;
  endtask
  task automatic test_dm_write;
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h0000_0010; dm_wdata = 32'hdead_beef;
    tick; dm_req = 1'b0; dm_we = 1'b0; dm_wdata = 32'h0;
    tick;
    checks++;
    if ({dm_gnt, mem_en, mem_we} !== 3'b111 || mem_addr !== 32'h10 || mem_wdata !== 32'hdead_beef) begin
      errors++; $display("FAIL dmw_c2 got %b addr %h wdata %h exp 111 addr 00000010 wdata deadbeef", {dm_gnt, mem_en, mem_we}, mem_addr, mem_wdata);
    end
    tick;
    checks++;
    if ({mem_en, mem_we, mem_wdata} !== {2'b00, 32'hdead_beef}) begin
      errors++; $display("FAIL dmw_c3 got %h exp 0deadbeef", {mem_en, mem_we, mem_wdata});
    end
    tick;
    checks++;
    if (dm_rdy !== 1'b1 || dm_rdata !== 32'h3c01_0001 || if_rdata !== 32'h3c01_0001) begin
      errors++; $display("FAIL dmw_c4 got rdy %b dm %h if %h exp rdy 1 dm 3c010001 if 3c010001", dm_rdy, dm_rdata, if_rdata);
    end
    checks++;
    if (wr_addr !== 32'h10 || wr_data !== 32'hdead_beef) begin
      errors++; $display("FAIL dmw_mem got %h %h exp 00000010 deadbeef", wr_addr, wr_data);
    end
    tick;
  endtask
  task automatic test_simul;
    int ig, dg;
    logic [3:0] e;
`ifdef MEM_ARB_RR_EN
    ig = 2; dg = 6;
`else
    ig = 6; dg = 2;
`endif
    if_req = 1'b1; if_addr = 32'h0000_3000;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h0000_0010;
    tick; if_req = 1'b0; dm_req = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      e = {c == ig, c == ig + 2, c == dg, c == dg + 2};
      checks++;
      if ({if_gnt, if_rdy, dm_gnt, dm_rdy} !== e) begin
        errors++; $display("FAIL simul_c%0d got %b exp %b", c, {if_gnt, if_rdy, dm_gnt, dm_rdy}, e);
      end
      tick;
    end
    checks++;
    if (dm_rdata !== 32'hdead_beef || busy !== 1'b0) begin
      errors++; $display("FAIL simul_end got %h busy %b exp deadbeef busy 0", dm_rdata, busy);
    end
  endtask
  task automatic test_ignore;
    int n = 0;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h0000_0010;
    tick; dm_addr = 32'h0000_3000;
    tick;
    checks++;
    if (dm_gnt !== 1'b1 || mem_addr !== 32'h10) begin
      errors++; $display("FAIL ign_c2 got gnt %b addr %h exp gnt 1 addr 00000010", dm_gnt, mem_addr);
    end
    tick; dm_req = 1'b0;
    for (int c = 3; c <= 9; c++) begin
      if (dm_gnt) n++;
      if (c == 4) begin
        checks++;
        if (dm_rdy !== 1'b1 || dm_rdata !== 32'hdead_beef) begin
          errors++; $display("FAIL ign_c4 got rdy %b data %h exp rdy 1 data deadbeef", dm_rdy, dm_rdata);
        end
      end
      tick;
    end
    checks++;
    if (n !== 0 || busy !== 1'b0) begin
      errors++; $display("FAIL ign_extra got %0d grants busy %b exp 0 grants busy 0", n, busy);
    end
  endtask
  task automatic test_starve;
    int dg[$];
    int ig[$];
    int rq = 0;
    int edg[5];
    int eig;
`ifdef MEM_ARB_RR_EN
    edg = '{6, 10, 14, 18, 22}; eig = 2;
`else
    edg = '{2, 6, 10, 14, 22}; eig = 18;
`endif
    if_req = 1'b1; if_addr = 32'h0000_3000;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h0000_0010;
    tick; if_req = 1'b0; dm_req = 1'b0;
    for (int c = 1; c <= 25; c++) begin
      if (dm_gnt) dg.push_back(c);
      if (if_gnt) ig.push_back(c);
`ifndef MEM_ARB_RR_EN
      if (c == 17 || c == 18) begin
        checks++;
        if (dut.st_cnt !== (c == 17 ? 3'd4 : 3'd0)) begin
          errors++; $display("FAIL st_cnt_c%0d got %0d exp %0d", c, dut.st_cnt, c == 17 ? 4 : 0);
        end
      end
`endif
      dm_req = dm_rdy && rq < 4;
      if (dm_rdy) rq++;
      tick;
    end
    dm_req = 1'b0;
    checks++;
    if (dg.size() !== 5 || ig.size() !== 1) begin
      errors++; $display("FAIL starve_count got dm %0d if %0d exp dm 5 if 1", dg.size(), ig.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (dg[i] !== edg[i]) begin
          errors++; $display("FAIL starve_dm%0d got cycle %0d exp %0d", i, dg[i], edg[i]);
        end
      end
      checks++;
      if (ig[0] !== eig) begin
        errors++; $display("FAIL starve_if got cycle %0d exp %0d", ig[0], eig);
      end
    end
  endtask
  task automatic test_reset_mid;
    int e;
    int bad = 0;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h0000_0010;
    tick; dm_req = 1'b0; if_req = 1'b1; if_addr = 32'h0000_3000;
    tick; if_req = 1'b0;
    checks++;
    if (dm_gnt !== 1'b1) begin
      errors++; $display("FAIL rmid_gnt got %b exp 1", dm_gnt);
    end
    tick; clr = 1'b0;
    tick; clr = 1'b1;
    checks++;
    if ({busy, dm_rdy, if_gnt, mem_en, dm_rdata} !== 36'h0) begin
      errors++; $display("FAIL rmid_after got %h exp 0", {busy, dm_rdy, if_gnt, mem_en, dm_rdata});
    end
    e = en_cnt;
    repeat (6) begin
      tick;
      if (dm_rdy || if_gnt || if_rdy || busy) bad++;
    end
    checks++;
    if (bad !== 0 || en_cnt !== e) begin
      errors++; $display("FAIL rmid_quiet got %0d events en %0d exp 0 events en %0d", bad, en_cnt, e);
    end
  endtask
  initial begin
    test_reset;
    test_if_read;
    test_dm_read;
    test_dm_write;
    test_simul;
    test_ignore;
    test_starve;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
